// File: rtl/rx_cmd_decoder_pkg.sv
// ----------------------------------------------------------------------------
// Module  : rx_cmd_decoder_pkg
// Brief   : UART system constants shared by the RX command decoder and the
//           TX-side response builder (command codes and FSM state encoding).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package rx_cmd_decoder_pkg;

  // Command bytes that open a frame
  localparam logic [7:0] c_cmd_write = 8'hAA;
  localparam logic [7:0] c_cmd_read  = 8'hBB;

  // Decoder FSM states; the TX builder decodes the same encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ISSUE   = 3'd4
  } rx_state_e;

endpackage : rx_cmd_decoder_pkg

`default_nettype wire

// File: rtl/rx_cmd_decoder.sv
// ----------------------------------------------------------------------------
// Module  : rx_cmd_decoder
// Brief   : Decodes UART byte frames (AA addr data / BB addr) into one-cycle
//           register-file write/read strobes, with inter-byte timeout and
//           frame-error reporting.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
#(
  parameter int DATA_width    = 8,
  parameter int ADDR_width    = 4,
  parameter int TIMEOUT_width = 16,
  parameter int TIMEOUT       = 5000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_width-1:0] P_DATA,
  input  logic                  data_valid,
  output logic [ADDR_width-1:0] RF_Address,
  output logic [DATA_width-1:0] RF_WrData,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic                  frame_err
);

  // Last counter value before the frame is abandoned; the counter never
  // advances past it, so it saturates instead of wrapping.
  localparam logic [TIMEOUT_width-1:0] c_timeout_last = TIMEOUT_width'(TIMEOUT - 1);
  localparam logic [DATA_width-1:0]    c_cmd_wr       = DATA_width'(c_cmd_write);
  localparam logic [DATA_width-1:0]    c_cmd_rd       = DATA_width'(c_cmd_read);

  rx_state_e                state_q;
  logic [TIMEOUT_width-1:0] cnt_q;
  logic [ADDR_width-1:0]    addr_q;
  logic [DATA_width-1:0]    wrdata_q;
  logic                     rd_pend_q;
  logic                     wren_q;
  logic                     rden_q;
  logic                     ferr_q;

  logic                     w_addr_ok;
  logic                     w_timeout_hit;

  // Address byte is legal only when no bit above the address field is set
  assign w_addr_ok     = ((P_DATA >> ADDR_width) == '0);
  assign w_timeout_hit = (cnt_q == c_timeout_last);

  // Frame FSM with inline timeout counter; all outputs are registered here
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      rd_pend_q <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      // Strobes and error are single-cycle pulses by default
      wren_q <= 1'b0;
      rden_q <= 1'b0;
      ferr_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (data_valid) begin
            if (P_DATA == c_cmd_wr) begin
              state_q <= ST_WR_ADDR;
            end else if (P_DATA == c_cmd_rd) begin
              state_q <= ST_RD_ADDR;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end

        ST_WR_ADDR, ST_RD_ADDR: begin
          // A byte arriving on the expiry cycle wins over the timeout
          if (data_valid) begin
            cnt_q <= '0;
            if (w_addr_ok) begin
              addr_q <= P_DATA[ADDR_width-1:0];
              if (state_q == ST_WR_ADDR) begin
                state_q <= ST_WR_DATA;
              end else begin
                rd_pend_q <= 1'b1;
                state_q   <= ST_ISSUE;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (w_timeout_hit) begin
            cnt_q   <= '0;
            ferr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WR_DATA: begin
          if (data_valid) begin
            cnt_q     <= '0;
            wrdata_q  <= P_DATA;
            rd_pend_q <= 1'b0;
            state_q   <= ST_ISSUE;
          end else if (w_timeout_hit) begin
            cnt_q   <= '0;
            ferr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_ISSUE: begin
          // Any byte seen here is dropped silently; the line rate cannot
          // deliver one this soon after the final byte of a frame.
          cnt_q   <= '0;
          wren_q  <= ~rd_pend_q;
          rden_q  <= rd_pend_q;
          state_q <= ST_IDLE;
        end

        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign RF_Address = addr_q;
  assign RF_WrData  = wrdata_q;
  assign RF_WrEn    = wren_q;
  assign RF_RdEn    = rden_q;
  assign frame_err  = ferr_q;

endmodule : rx_cmd_decoder

`default_nettype wire

// File: tb/tb_rx_cmd_decoder.sv
// ----------------------------------------------------------------------------
// Module  : tb_rx_cmd_decoder
// Brief   : Directed self-checking bench for rx_cmd_decoder.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rx_cmd_decoder;

  localparam int c_dw = 8;
  localparam int c_aw = 4;
  localparam int c_tw = 16;
  localparam int c_to = 5000;

  logic            clk;
  logic            reset_n;
  logic [c_dw-1:0] P_DATA;
  logic            data_valid;
  logic [c_aw-1:0] RF_Address;
  logic [c_dw-1:0] RF_WrData;
  logic            RF_WrEn;
  logic            RF_RdEn;
  logic            frame_err;

  int total;
  int bad;

  rx_cmd_decoder #(
    .DATA_width   (c_dw),
    .ADDR_width   (c_aw),
    .TIMEOUT_width(c_tw),
    .TIMEOUT      (c_to)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .RF_Address(RF_Address),
    .RF_WrData (RF_WrData),
    .RF_WrEn   (RF_WrEn),
    .RF_RdEn   (RF_RdEn),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single cycle; returns 1 time unit after the
  // edge that sampled it.
  task automatic send_byte(input logic [c_dw-1:0] b);
    @(posedge clk);
    #1;
    P_DATA     = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    P_DATA     = '0;
    data_valid = 1'b0;

    // Reset state
    idle(3);
    check("rst_wren", 32'(RF_WrEn), 32'd0);
    check("rst_rden", 32'(RF_RdEn), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_addr", 32'(RF_Address), 32'd0);
    check("rst_wdat", 32'(RF_WrData), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Write frame AA 05 3C, bytes 160 cycles apart
    send_byte(8'hAA);
    check("w1_ferr_cmd", 32'(frame_err), 32'd0);
    idle(159);
    send_byte(8'h05);
    check("w1_ferr_addr", 32'(frame_err), 32'd0);
    idle(159);
    send_byte(8'h3C);
    check("w1_wren_early", 32'(RF_WrEn), 32'd0);
    idle(1);
    check("w1_wren", 32'(RF_WrEn), 32'd1);
    check("w1_rden", 32'(RF_RdEn), 32'd0);
    check("w1_ferr", 32'(frame_err), 32'd0);
    check("w1_addr", 32'(RF_Address), 32'h5);
    check("w1_wdat", 32'(RF_WrData), 32'h3C);
    idle(1);
    check("w1_wren_off", 32'(RF_WrEn), 32'd0);

    // Read frame BB 0A
    send_byte(8'hBB);
    send_byte(8'h0A);
    check("r1_rden_early", 32'(RF_RdEn), 32'd0);
    idle(1);
    check("r1_rden", 32'(RF_RdEn), 32'd1);
    check("r1_wren", 32'(RF_WrEn), 32'd0);
    check("r1_ferr", 32'(frame_err), 32'd0);
    check("r1_addr", 32'(RF_Address), 32'hA);
    check("r1_wdat", 32'(RF_WrData), 32'h3C);
    idle(1);
    check("r1_rden_off", 32'(RF_RdEn), 32'd0);

    // Unknown command, then a normal write frame
    send_byte(8'h17);
    check("bad_cmd_ferr", 32'(frame_err), 32'd1);
    idle(1);
    check("bad_cmd_ferr_off", 32'(frame_err), 32'd0);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h5A);
    idle(1);
    check("w2_wren", 32'(RF_WrEn), 32'd1);
    check("w2_addr", 32'(RF_Address), 32'h2);
    check("w2_wdat", 32'(RF_WrData), 32'h5A);

    // Address out of range aborts the frame; address register untouched
    idle(3);
    send_byte(8'hAA);
    send_byte(8'h15);
    check("oor_ferr", 32'(frame_err), 32'd1);
    check("oor_addr_hold", 32'(RF_Address), 32'h2);
    idle(1);
    check("oor_ferr_off", 32'(frame_err), 32'd0);
    check("oor_wren0", 32'(RF_WrEn), 32'd0);
    idle(1);
    check("oor_wren1", 32'(RF_WrEn), 32'd0);

    // Timeout: no byte after AA
    idle(3);
    send_byte(8'hAA);
    repeat (c_to - 1) @(posedge clk);
    #1;
    check("to_ferr_before", 32'(frame_err), 32'd0);
    idle(1);
    check("to_ferr", 32'(frame_err), 32'd1);
    idle(1);
    check("to_ferr_off", 32'(frame_err), 32'd0);
    check("to_wren", 32'(RF_WrEn), 32'd0);

    // Byte on the expiry cycle wins; frame continues
    idle(3);
    send_byte(8'hAA);
    repeat (c_to - 2) @(posedge clk);
    send_byte(8'h05);
    check("to_edge_ferr", 32'(frame_err), 32'd0);
    idle(1);
    check("to_edge_ferr2", 32'(frame_err), 32'd0);
    send_byte(8'h77);
    idle(1);
    check("to_edge_wren", 32'(RF_WrEn), 32'd1);
    check("to_edge_addr", 32'(RF_Address), 32'h5);
    check("to_edge_wdat", 32'(RF_WrData), 32'h77);

    // Reset mid-frame discards it; next byte is a bad command
    idle(3);
    send_byte(8'hAA);
    send_byte(8'h03);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    check("mrst_addr", 32'(RF_Address), 32'h0);
    check("mrst_wdat", 32'(RF_WrData), 32'h0);
    check("mrst_wren", 32'(RF_WrEn), 32'd0);
    check("mrst_ferr", 32'(frame_err), 32'd0);
    send_byte(8'h44);
    check("mrst_44_ferr", 32'(frame_err), 32'd1);
    check("mrst_44_wren", 32'(RF_WrEn), 32'd0);
    idle(1);
    check("mrst_44_wren2", 32'(RF_WrEn), 32'd0);
    check("mrst_44_rden2", 32'(RF_RdEn), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rx_cmd_decoder

`default_nettype wire
